// File: rtl/seg7_capture.sv
// seg7_capture: rebuilds the word shown on a multiplexed active-low 7-segment display.
// Ports:
//   clk      in   system clock, rising edge
//   clr      in   synchronous active-high reset
//   an       in   [3:0] anodes, active-low, an[0] = rightmost digit = value[3:0]
//   seg      in   [6:0] segments, active-low, seg[0]=a .. seg[6]=g
//   dp       in   decimal point, active-low
//   value    out  [15:0] last completed frame
//   blank    out  [3:0] per-digit blank mask
//   dp_mask  out  [3:0] per-digit lit decimal point mask
//   valid    out  one-cycle strobe per completed frame
//   err      out  frame contained an unrecognised glyph (qualified by valid)
//   stale    out  no complete frame seen within TIMEOUT cycles
module seg7_capture #(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT       = 4194304
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic [3:0]  dp_mask,
    output logic        valid,
    output logic        err,
    output logic        stale
);
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);

    // Decoded glyph: {error, blank, nibble}; segment bits ordered g..a.
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 6'h00;
            7'b1111001: decode = 6'h01;
            7'b0100100: decode = 6'h02;
            7'b0110000: decode = 6'h03;
            7'b0011001: decode = 6'h04;
            7'b0010010: decode = 6'h05;
            7'b0000010: decode = 6'h06;
            7'b1111000: decode = 6'h07;
            7'b0000000: decode = 6'h08;
            7'b0010000: decode = 6'h09;
            7'b0001000: decode = 6'h0a;
            7'b0000011: decode = 6'h0b;
            7'b1000110: decode = 6'h0c;
            7'b0100001: decode = 6'h0d;
            7'b0000110: decode = 6'h0e;
            7'b0001110: decode = 6'h0f;
            7'b1111111: decode = 6'h10;
            default:    decode = 6'h20;
        endcase
    endfunction

    logic [11:0]     in_q, prev_q;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            held_q, held_d;
    logic [3:0]      seen_q, seen_d;
    logic [3:0][3:0] nib_q, nib_d;
    logic [3:0]      blk_q, blk_d, dpm_q, dpm_d, er_q, er_d;
    logic [15:0]     value_q, value_d;
    logic [3:0]      blank_q, blank_d, dp_mask_q, dp_mask_d;
    logic            valid_q, valid_d, err_q, err_d, stale_q, stale_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;

    logic [3:0] an_r;
    logic       an_ok, stable, accept, complete;
    logic [1:0] slot;
    logic [5:0] dec;

    always_comb begin
        an_r     = in_q[11:8];
        an_ok    = an_r inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
        // Only a qualified anode pattern may build up stability.
        stable   = an_ok && (in_q == prev_q);
        cnt_d    = !stable ? '0 : (cnt_q == S_MAX ? cnt_q : cnt_q + 1'b1);
        accept   = stable && (cnt_d == S_MAX) && !held_q;
        held_d   = stable && (held_q || accept);
        slot     = an_r == 4'b1110 ? 2'd0 : an_r == 4'b1101 ? 2'd1 : an_r == 4'b1011 ? 2'd2 : 2'd3;
        dec      = decode(in_q[7:1]);
        complete = &seen_q;
        seen_d   = (complete ? 4'b0 : seen_q) | (accept ? ~an_r : 4'b0);
        nib_d    = nib_q;
        blk_d    = blk_q;
        dpm_d    = dpm_q;
        er_d     = complete ? 4'b0 : er_q;
        if (accept) begin
            nib_d[slot] = dec[3:0];
            blk_d[slot] = dec[4];
            dpm_d[slot] = ~in_q[0];
            er_d[slot]  = dec[5];
        end
        value_d   = complete ? nib_q : value_q;
        blank_d   = complete ? blk_q : blank_q;
        dp_mask_d = complete ? dpm_q : dp_mask_q;
        err_d     = complete ? |er_q : err_q;
        valid_d   = complete;
        // Completion takes priority over expiry in the same cycle.
        tcnt_d    = complete ? '0 : (tcnt_q == T_MAX ? tcnt_q : tcnt_q + 1'b1);
        stale_d   = !complete && (stale_q || tcnt_d == T_MAX);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            in_q      <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            held_q    <= 1'b0;
            seen_q    <= '0;
            nib_q     <= '0;
            blk_q     <= '0;
            dpm_q     <= '0;
            er_q      <= '0;
            value_q   <= '0;
            blank_q   <= '0;
            dp_mask_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            stale_q   <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            in_q      <= {an, seg, dp};
            prev_q    <= in_q;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            seen_q    <= seen_d;
            nib_q     <= nib_d;
            blk_q     <= blk_d;
            dpm_q     <= dpm_d;
            er_q      <= er_d;
            value_q   <= value_d;
            blank_q   <= blank_d;
            dp_mask_q <= dp_mask_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            stale_q   <= stale_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign value   = value_q;
    assign blank   = blank_q;
    assign dp_mask = dp_mask_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign stale   = stale_q;
endmodule
